// File: rtl/brisc_pkg.sv
// Shared core constants and types used by the multiplier pipe.
package brisc_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_BITS  = 5;
    localparam int unsigned MUL_DELAY = 5;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    // One pipeline slot; fields not yet meaningful at a given depth stay zero.
    typedef struct packed {
        mul_op_e             op;
        logic [REG_BITS-1:0] rd;
        logic [XLEN:0]       a;
        logic [XLEN:0]       b;
        logic [2*XLEN-1:0]   prod;
        logic [XLEN-1:0]     res;
    } mul_pay_t;

    function automatic logic [XLEN:0] mul_ext(logic [XLEN-1:0] v, logic sgn);
        return {sgn & v[XLEN-1], v};
    endfunction

    function automatic logic [XLEN-1:0] mul_select(mul_op_e op, logic [2*XLEN-1:0] p);
        return (op == MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Issue/result signal bundle between the A stage, the multiplier and the hazard unit.
interface mul_pipe_if;
    import brisc_pkg::*;

    logic                valid_A_in;
    mul_op_e             op_A_in;
    logic [XLEN-1:0]     rs1_val_A_in;
    logic [XLEN-1:0]     rs2_val_A_in;
    logic [REG_BITS-1:0] rd_A_in;
    logic                stall_A_in;
    logic                flush_A_in;
    logic                valids_M_out [MUL_DELAY-1];
    logic                valid_M_out;
    logic [XLEN-1:0]     result_M_out;
    logic [REG_BITS-1:0] rd_M_out;

    modport master (
        output valid_A_in, op_A_in, rs1_val_A_in, rs2_val_A_in, rd_A_in,
        output stall_A_in, flush_A_in,
        input  valids_M_out, valid_M_out, result_M_out, rd_M_out
    );

    modport slave (
        input  valid_A_in, op_A_in, rs1_val_A_in, rs2_val_A_in, rd_A_in,
        input  stall_A_in, flush_A_in,
        output valids_M_out, valid_M_out, result_M_out, rd_M_out
    );

endinterface

// File: rtl/mul_pipe_stage.sv
// One pipeline slot: valid plus payload, held while stalled, cleared by reset.
module mul_stage #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hold_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (!hold_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mul_pipe.sv
// Fixed-latency RV32M multiplier on the A->C path; stall freezes every stage,
// flush only gates capture into stage 0.
module mul_pipe
    import brisc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_A_in,
    input  mul_op_e             op_A_in,
    input  logic [XLEN-1:0]     rs1_val_A_in,
    input  logic [XLEN-1:0]     rs2_val_A_in,
    input  logic [REG_BITS-1:0] rd_A_in,
    input  logic                stall_A_in,
    input  logic                flush_A_in,
    output logic                valids_M_out [MUL_DELAY-1],
    output logic                valid_M_out,
    output logic [XLEN-1:0]     result_M_out,
    output logic [REG_BITS-1:0] rd_M_out
);

    if (MUL_DELAY < 2) begin : g_bad_delay
        $error("mul_pipe needs MUL_DELAY >= 2");
    end

    logic     valid_q [MUL_DELAY];
    mul_pay_t stage_q [MUL_DELAY];

    for (genvar g = 0; g < MUL_DELAY; g++) begin : g_stage
        mul_pay_t stage_d;
        logic     valid_d;

        if (g == 0) begin : g_capture
            // Operands widened by one bit so every op is a single signed multiply.
            always_comb begin
                stage_d      = '0;
                stage_d.op   = op_A_in;
                stage_d.rd   = rd_A_in;
                stage_d.a    = mul_ext(rs1_val_A_in, op_A_in != MULHU);
                stage_d.b    = mul_ext(rs2_val_A_in, (op_A_in == MUL) || (op_A_in == MULH));
            end
            assign valid_d = valid_A_in & ~flush_A_in;
        end else if (g == 1) begin : g_mul
            always_comb begin
                stage_d      = stage_q[0];
                stage_d.prod = 64'($signed(stage_q[0].a)) * 64'($signed(stage_q[0].b));
                if (g == MUL_DELAY - 1) begin
                    stage_d.res = mul_select(stage_d.op, stage_d.prod);
                end
            end
            assign valid_d = valid_q[0];
        end else begin : g_pass
            always_comb begin
                stage_d = stage_q[g-1];
                if (g == MUL_DELAY - 1) begin
                    stage_d.res = mul_select(stage_d.op, stage_d.prod);
                end
            end
            assign valid_d = valid_q[g-1];
        end

        mul_stage #(.W($bits(mul_pay_t))) u_stage (
            .clk     (clk),
            .reset   (reset),
            .hold_i  (stall_A_in),
            .valid_i (valid_d),
            .data_i  (stage_d),
            .valid_o (valid_q[g]),
            .data_o  (stage_q[g])
        );
    end

    for (genvar i = 0; i < MUL_DELAY - 1; i++) begin : g_occ
        assign valids_M_out[i] = valid_q[i];
    end

    assign valid_M_out  = valid_q[MUL_DELAY-1];
    assign result_M_out = stage_q[MUL_DELAY-1].res;
    assign rd_M_out     = stage_q[MUL_DELAY-1].rd;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboarded random/directed bench for mul_pipe with a 64-bit arithmetic reference.
module tb_mul_pipe;
    import brisc_pkg::*;

    localparam int unsigned D = MUL_DELAY;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_pipe_if bus();

    mul_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .valid_A_in   (bus.valid_A_in),
        .op_A_in      (bus.op_A_in),
        .rs1_val_A_in (bus.rs1_val_A_in),
        .rs2_val_A_in (bus.rs2_val_A_in),
        .rd_A_in      (bus.rd_A_in),
        .stall_A_in   (bus.stall_A_in),
        .flush_A_in   (bus.flush_A_in),
        .valids_M_out (bus.valids_M_out),
        .valid_M_out  (bus.valid_M_out),
        .result_M_out (bus.result_M_out),
        .rd_M_out     (bus.rd_M_out)
    );

    typedef struct {
        longint unsigned tag;
        logic [4:0]      rd;
        logic [31:0]     res;
    } exp_t;

    exp_t            q[$];
    longint unsigned adv = 0;
    int unsigned     vectors = 0;
    int unsigned     miscompares = 0;
    logic [31:0]     cur_exp = '0;
    bit              mon_en = 1'b0;

    function automatic logic [31:0] ref_mul(mul_op_e op, logic [31:0] a, logic [31:0] b);
        longint          sa, sb, ub, p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            default: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
        endcase
    endfunction

    // Reference: an accepted op is due once MUL_DELAY-1 further unstalled edges pass.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
        end else if (!bus.stall_A_in) begin
            adv++;
            if (bus.valid_A_in && !bus.flush_A_in)
                q.push_back('{adv, bus.rd_A_in, cur_exp});
        end
    end

    always @(negedge clk) begin : monitor
        logic [D-2:0] exp_occ, act_occ;
        bit           exp_out;
        if (mon_en) begin
            exp_occ = '0;
            foreach (q[k])
                if (adv - q[k].tag < D - 1) exp_occ[adv - q[k].tag] = 1'b1;
            for (int i = 0; i < D - 1; i++) act_occ[i] = bus.valids_M_out[i];
            exp_out = (q.size() > 0) && (adv - q[0].tag == D - 1);

            vectors++;
            if (act_occ !== exp_occ) begin
                miscompares++;
                $display("FAIL occupancy t=%0t got=%b want=%b", $time, act_occ, exp_occ);
            end
            vectors++;
            if (bus.valid_M_out !== exp_out) begin
                miscompares++;
                $display("FAIL valid_M t=%0t got=%b want=%b", $time, bus.valid_M_out, exp_out);
            end
            if (exp_out) begin
                vectors++;
                if (bus.result_M_out !== q[0].res || bus.rd_M_out !== q[0].rd) begin
                    miscompares++;
                    $display("FAIL result t=%0t got=%h/rd%0d want=%h/rd%0d",
                             $time, bus.result_M_out, bus.rd_M_out, q[0].res, q[0].rd);
                end
                if (!bus.stall_A_in) void'(q.pop_front());
            end
        end
    end

    task automatic drive(bit v, mul_op_e op, logic [31:0] a, logic [31:0] b,
                         logic [4:0] rd, bit st, bit fl, logic [31:0] e);
        @(posedge clk);
        #1;
        bus.valid_A_in   = v;
        bus.op_A_in      = op;
        bus.rs1_val_A_in = a;
        bus.rs2_val_A_in = b;
        bus.rd_A_in      = rd;
        bus.stall_A_in   = st;
        bus.flush_A_in   = fl;
        cur_exp          = e;
    endtask

    task automatic idle(int unsigned n);
        for (int unsigned i = 0; i < n; i++) drive(1'b0, MUL, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic issue(mul_op_e op, logic [31:0] a, logic [31:0] b, logic [4:0] rd, logic [31:0] e);
        drive(1'b1, op, a, b, rd, 1'b0, 1'b0, e);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.valid_A_in = 1'b0; bus.op_A_in = MUL; bus.rs1_val_A_in = '0;
        bus.rs2_val_A_in = '0; bus.rd_A_in = '0; bus.stall_A_in = 1'b0; bus.flush_A_in = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1; mon_en = 1'b1;
        @(posedge clk); #1; reset = 1'b0;

        // Reset mid-flight kills the op.
        issue(MUL, 32'd3, 32'd4, 5'd1, 32'd12);
        idle(1);
        @(posedge clk); #1; reset = 1'b1; bus.valid_A_in = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        vectors++;
        if (bus.valid_M_out !== 1'b0 || bus.result_M_out !== '0 || bus.rd_M_out !== '0 ||
            bus.valids_M_out[0] !== 1'b0 || bus.valids_M_out[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clear got v=%b res=%h rd=%0d want 0/0/0",
                     bus.valid_M_out, bus.result_M_out, bus.rd_M_out);
        end
        idle(8);

        // Directed ops and corners, spaced to exercise single-issue occupancy.
        issue(MUL,    32'd7,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB); idle(6);
        issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE); idle(6);
        issue(MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd7, 32'hFFFF_FFFF); idle(6);
        issue(MULH,   32'h8000_0000, 32'h8000_0000, 5'd0, 32'h4000_0000); idle(6);

        // Stall mid-pipe with a non-captured valid, then stall on a presented result.
        issue(MUL, 32'd100, 32'd200, 5'd8, 32'd20000);
        idle(1);
        for (int i = 0; i < 3; i++) drive(1'b1, MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd31, 1'b1, 1'b0, '0);
        idle(8);
        issue(MULH, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, ref_mul(MULH, 32'h1234_5678, 32'h9ABC_DEF0));
        idle(4);
        for (int i = 0; i < 3; i++) drive(1'b0, MUL, '0, '0, '0, 1'b1, 1'b0, '0);
        idle(6);

        // Flush alone, and flush under stall with an op in flight.
        drive(1'b1, MUL, 32'd5, 32'd5, 5'd3, 1'b0, 1'b1, 32'd25);
        idle(6);
        issue(MUL, 32'd6, 32'd9, 5'd4, 32'd54);
        drive(1'b1, MUL, 32'd2, 32'd2, 5'd2, 1'b1, 1'b1, 32'd4);
        idle(7);

        // Back-to-back issue.
        for (int i = 0; i < 5; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            issue(MUL, a, b, 5'(10 + i), ref_mul(MUL, a, b));
        end
        idle(8);

        // Random traffic with stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            mul_op_e     op;
            logic [31:0] a, b;
            op = mul_op_e'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            drive(1'($urandom_range(0, 1)), op, a, b, 5'($urandom), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0), ref_mul(op, a, b));
        end
        idle(12);

        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d outstanding want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Fixed-latency pipelined RV32M multiplier occupying the A→C path, in parallel with the ALU.
- Accepts one multiply per cycle from the A stage. Returns the result and destination register after exactly MUL_DELAY cycles.
- Drives per-stage occupancy (valids_M) to the hazard unit and honours that unit's stall and flush outputs, so it sits at the other end of the stall/flush interface.

Parameters:
- XLEN, 32, operand/result width (from brisc_pkg).
- REG_BITS, 5, register index width (from brisc_pkg).
- MUL_DELAY, 5, total pipeline depth in stages; minimum 2 (from brisc_pkg).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_A_in  in  1  multiply instruction present in A stage
- op_A_in  in  mul_op_e (2)  MUL / MULH / MULHSU / MULHU
- rs1_val_A_in  in  XLEN  operand a (forwarded value)
- rs2_val_A_in  in  XLEN  operand b (forwarded value)
- rd_A_in  in  REG_BITS  destination register
- stall_A_in  in  1  hazard stall_A_out; freezes the whole pipe
- flush_A_in  in  1  hazard flush_A_out; kills the entry being accepted
- valids_M_out  out  logic [MUL_DELAY-1] unpacked  valid of stages 0..MUL_DELAY-2, to hazard valids_M_in
- valid_M_out  out  1  result valid (last stage)
- result_M_out  out  XLEN  result
- rd_M_out  out  REG_BITS  destination of result

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Stage registers S[0..MUL_DELAY-1] each hold {valid, op, rd, datapath payload}.
  - valids_M_out[i] = S[i].valid for i < MUL_DELAY-1.
  - valid_M_out, result_M_out and rd_M_out come from S[MUL_DELAY-1]. All outputs are registered.
- Reset: every valid clears to 0 on the clocking edge with reset=1. result_M_out and rd_M_out reset to 0. Reset overrides stall and flush, and kills everything in flight.
- Normal advance (stall_A_in=0):
  - S[0].valid <= valid_A_in & ~flush_A_in.
  - S[i] <= S[i-1] for i ≥ 1.
  - Payload may load unconditionally; only the valid is gated.
- Stall (stall_A_in=1): all stages hold, including the output stage, and valid_A_in is ignored. A stalled result stays valid and stable on the outputs.
- Stall has priority over flush. flush_A_in affects only the entry at S[0] capture, never in-flight entries, which are older than the branch.
- Latency: an instruction accepted in cycle t (valid=1, no stall, no flush) gives valid_M_out=1 in cycle t+MUL_DELAY, plus one cycle per stalled cycle in between. Throughput is 1 per cycle when unstalled.
- Pipeline bubbles: the hazard unit's mul_stall normally blocks issue while any S[0..MUL_DELAY-2] is valid. The pipe must nonetheless handle back-to-back valid inputs correctly, with no dependence on that serialisation.
- Arithmetic: form the 2·XLEN-bit product of a and b.
  - MUL: signed×signed, low XLEN bits.
  - MULH: signed×signed, high XLEN bits.
  - MULHSU: signed a × unsigned b, high XLEN bits.
  - MULHU: unsigned×unsigned, high XLEN bits.
  - Implementation: sign/zero-extend each operand to XLEN+1 bits and do a signed (XLEN+1)×(XLEN+1) multiply.
  - The product may be split across stages (e.g. 16-bit partial products summed in later stages), but the result must be bit-exact at the last stage.
- Corner cases:
  - MULH of 0x80000000×0x80000000 = 0x40000000.
  - MULHU of 0xFFFFFFFF×0xFFFFFFFF = 0xFFFFFFFE.
  - Results with rd=0 are produced normally; writeback discards them.
- Invalid stages: payload is don't-care; the verifier checks payload only when the corresponding valid=1.

Decomposition:
- brisc_pkg gains:
  - typedef enum logic [1:0] mul_op_e {MUL, MULH, MULHSU, MULHU};
  - a static assertion that MUL_DELAY ≥ 2.
- XLEN, REG_BITS and MUL_DELAY already live there.
- One sub-module, mul_stage: a parameterised payload register with valid, hold-on-stall and synchronous clear. It is instantiated MUL_DELAY times via generate.

Test Plan:
1. Reset mid-flight: issue MUL 3×4, assert reset at cycle 2 → all valids 0 on the next cycle, valid_M_out never rises, outputs 0.
2. Latency and ops:
   - MUL 7×(-3) at t → cycle t+5: valid_M_out=1, result 0xFFFFFFEB, rd as issued.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
   - MULH 0x80000000×0x80000000 → 0x40000000.
3. Occupancy: single issue at t → valids_M_out[0..3] walks a single 1 through cycles t+1..t+4; the hazard-visible OR is 1 exactly in t+1..t+4.
4. Stall: issue at t, stall_A_in=1 during t+2..t+4 → result valid at t+8; output held unchanged while stalled with valid_M_out=1; valid_A_in during stall not captured.
5. Flush: valid_A_in=1 with flush_A_in=1 → entry never appears. Same cycle with stall_A_in=1 also set → no state change.
6. Back-to-back: five consecutive MULs with distinct rd, no stalls → five consecutive valid results, in order, each correct.
